execute_stage_md: RTL
=====================

Name: execute_stage_md

Overview:
- Parametrised successor of the pipelined MIPS execute stage.
- Keeps the 4:1 forwarding muxes, the ALUSrc mux, the RegDst mux and the combinational ALU, all generalised in width.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and mthi/mtlo/mfhi/mflo support.
- Drives a stall request to the hazard unit while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, datapath width in bits (minimum 4).
- REG_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- E_RD1_E, E_RD2_E  in  WIDTH  register-file operands.
- E_Result_W, E_ALU_out_M  in  WIDTH  forwarded values from W and M.
- E_signImm_E  in  WIDTH  sign-extended immediate.
- E_ALU_control_E  in  3  ALU operation select (unchanged encoding).
- E_Rt_E, E_Rd_E  in  REG_W  destination candidates.
- E_ALUSrc_E, E_reg_dest_E  in  1  srcB and destination selects.
- E_forwardA_E, E_forwardB_E  in  2  forwarding selects: 00 RD, 01 Result_W, 10 ALU_out_M, 11 zero.
- E_md_op_E  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- E_md_read_E  in  2  result select: 00 ALU, 01 HI, 10 LO, 11 ALU.
- E_writeData_E  out  WIDTH  forwarded srcB before the immediate mux.
- E_ALU_out_E  out  WIDTH  stage result: ALU, HI or LO, per E_md_read_E.
- E_writeReg_E  out  REG_W  destination register.
- E_md_stall_E  out  1  stall request to the hazard unit.
- E_div_zero_E  out  1  one-cycle pulse when a divide by zero completes.

Behaviour:
- Forwarding, ALUSrc, RegDst and ALU paths are combinational and behave as in the existing stage at any WIDTH.
- Multiply and divide operands are always forwarded srcA and E_writeData_E; the immediate is never used.
- FSM states: IDLE, RUN, FIX. Iteration counter is clog2(WIDTH)+1 bits.
- Start condition: state==IDLE and E_md_op_E is one of 001..100.
  - Latch operand magnitudes (absolute value for the signed ops) and result signs.
  - Clear the counter and go to RUN.
  - The start instruction itself is not stalled: it proceeds with result ALU/HI/LO as selected.
- RUN, mult/multu: one shift-add step per cycle, 2*WIDTH-bit product.
- RUN, div/divu: one restoring-division step per cycle.
- RUN lasts exactly WIDTH cycles, then the FSM goes to FIX.
- FIX: apply signs, write HI/LO on this edge, return to IDLE.
  - mult: HI = upper half, LO = lower half.
  - div: LO = quotient, HI = remainder.
  - Signed div: the quotient sign is the XOR of the operand signs; the remainder takes the sign of the dividend.
- Latency: with start at edge 0, HI/LO are updated at edge WIDTH+1. State is non-IDLE for exactly WIDTH+1 cycles.
- Divide by zero:
  - Result is LO = all ones, HI = dividend (as presented, including its sign).
  - E_div_zero_E is high for the single cycle following the FIX edge.
  - Timing is the same as a normal divide.
- Signed MIN / -1: LO = MIN, HI = 0, no flag.
- mthi/mtlo in IDLE write srcA into HI/LO at the next edge, single cycle, no stall.
- E_md_stall_E = (state != IDLE) AND (E_md_op_E in 001..110, or E_md_read_E in {01, 10}). It is combinational.
- While stalled, the held instruction is re-presented. On the cycle the state returns to IDLE, the stall drops:
  - a held op starts, or
  - a held mfhi/mflo reads the just-written HI/LO.
- Independent ALU instructions issue freely during RUN/FIX.
- mthi/mtlo immediately followed by mfhi/mflo returns the new value (register write, then read next cycle).
- Reset (asynchronous, any time including mid-RUN):
  - state IDLE, HI = LO = 0, counter and working registers 0;
  - E_md_stall_E = 0, E_div_zero_E = 0;
  - the in-flight operation is abandoned.
- Combinational outputs follow their inputs during reset, with HI/LO reads returning 0.

Decomposition:
- Shared package mips_pkg holds:
  - md_op codes;
  - md_read codes;
  - ALU control codes;
  - FSM state encoding.
- One sub-module, mul_div_unit, holds the FSM, counter, working registers, HI/LO and the div-zero pulse.
- The top level keeps the muxes, the ALU and the stall equation.

Test Plan:
- WIDTH=32, multu 0xFFFFFFFF x 0xFFFFFFFF, then mfhi next cycle -> stall exactly 33 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- mult -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 -> LO=0xFFFFFFFF, HI=100, E_div_zero_E high for one cycle after completion. div 0x80000000 / -1 -> LO=0x80000000, HI=0, no flag.
- mult with srcA forwarded from E_ALU_out_M (fwdA=10); then 5 independent add instructions -> no stall, correct ALU outputs; back-to-back mult -> second stalls until the first completes.
- mthi 0x1234 then mfhi next cycle -> E_ALU_out_E=0x1234, no stall.
- rst asserted mid-RUN at iteration 10 -> immediately state IDLE, stall 0, HI=LO=0. WIDTH=8 exhaustive signed/unsigned mul/div against a reference model.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage with multiply/divide support:
// md_op and md_read codes, ALU control codes and the mul/div FSM states.
package mips_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_RSVD  = 3'b111
   } md_op_e;

   localparam logic [1:0] MDR_ALU     = 2'b00;
   localparam logic [1:0] MDR_HI      = 2'b01;
   localparam logic [1:0] MDR_LO      = 2'b10;
   localparam logic [1:0] MDR_ALU_ALT = 2'b11;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_ANDN = 3'b100;
   localparam logic [2:0] ALU_ORN  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } md_state_e;

   // True for the four ops that launch a multi-cycle multiply or divide.
   function automatic logic is_md_start(input logic [2:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // True for every op that needs the mul/div unit (start or HI/LO write).
   function automatic logic is_md_use(input logic [2:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// architectural HI/LO registers, mthi/mtlo writes and the div-by-zero pulse.
module mul_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Two's complement negate when n is set (WIDTH bits).
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
      if (n) return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      else   return v;
   endfunction

   // Two's complement negate when n is set (2*WIDTH bits).
   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
      if (n) return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
      else   return v;
   endfunction

   md_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             by_zero;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic             signed_op;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             take;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   // Operand magnitudes and signs presented at the start of an operation.
   always_comb begin
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      sign_a    = signed_op & src_a[WIDTH-1];
      sign_b    = signed_op & src_b[WIDTH-1];
      mag_a     = cond_neg(src_a, sign_a);
      mag_b     = cond_neg(src_b, sign_b);
   end

   // One iteration: shift-add for multiply, restoring step for divide.
   always_comb begin
      add_sum = {1'b0, work_hi} + {1'b0, mcand};
      shifted = {work_hi, work_lo[WIDTH-1]};
      trial   = shifted[WIDTH-1:0] - mcand;
      take    = shifted[WIDTH] | (shifted[WIDTH-1:0] >= mcand);
      if (is_div) begin
         if (take) begin
            step_hi = trial;
            step_lo = {work_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shifted[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (work_lo[0]) begin
            {step_hi, step_lo} = {add_sum, work_lo[WIDTH-1:1]};
         end else begin
            {step_hi, step_lo} = {1'b0, work_hi, work_lo[WIDTH-1:1]};
         end
      end
   end

   // Sign correction applied in the FIX state.
   always_comb begin
      prod_fix = cond_neg2({work_hi, work_lo}, neg_q);
      quot_fix = cond_neg(work_lo, neg_q);
      rem_fix  = cond_neg(work_hi, neg_r);
   end

   assign busy = (state != ST_IDLE);

   // FSM, iteration counter, working registers, HI/LO and div-zero pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= {CNT_W{1'b0}};
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         by_zero  <= 1'b0;
         mcand    <= {WIDTH{1'b0}};
         work_hi  <= {WIDTH{1'b0}};
         work_lo  <= {WIDTH{1'b0}};
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
         div_zero <= 1'b0;
      end else begin
         div_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (is_md_start(op)) begin
                  is_div  <= (op == MD_DIV) || (op == MD_DIVU);
                  neg_q   <= sign_a ^ sign_b;
                  neg_r   <= sign_a;
                  by_zero <= (src_b == {WIDTH{1'b0}});
                  work_hi <= {WIDTH{1'b0}};
                  cnt     <= {CNT_W{1'b0}};
                  state   <= ST_RUN;
                  if ((op == MD_DIV) || (op == MD_DIVU)) begin
                     work_lo <= mag_a;
                     mcand   <= mag_b;
                  end else begin
                     work_lo <= mag_b;
                     mcand   <= mag_a;
                  end
               end else if (op == MD_MTHI) begin
                  hi <= src_a;
               end else if (op == MD_MTLO) begin
                  lo <= src_a;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               work_hi <= step_hi;
               work_lo <= step_lo;
               cnt     <= cnt + CNT_ONE;
               if (cnt == CNT_LAST) begin
                  state <= ST_FIX;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_FIX: begin
               if (is_div) begin
                  // Divide by zero leaves the dividend in the remainder path.
                  lo       <= by_zero ? {WIDTH{1'b1}} : quot_fix;
                  hi       <= rem_fix;
                  div_zero <= by_zero;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/execute_stage_md.sv
// Pipelined MIPS execute stage: forwarding muxes, ALUSrc/RegDst muxes,
// combinational ALU, and an iterative multiply/divide unit with HI/LO.
module execute_stage_md
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] E_RD1_E,
   input  logic [WIDTH-1:0] E_RD2_E,
   input  logic [WIDTH-1:0] E_Result_W,
   input  logic [WIDTH-1:0] E_ALU_out_M,
   input  logic [WIDTH-1:0] E_signImm_E,
   input  logic [2:0]       E_ALU_control_E,
   input  logic [REG_W-1:0] E_Rt_E,
   input  logic [REG_W-1:0] E_Rd_E,
   input  logic             E_ALUSrc_E,
   input  logic             E_reg_dest_E,
   input  logic [1:0]       E_forwardA_E,
   input  logic [1:0]       E_forwardB_E,
   input  logic [2:0]       E_md_op_E,
   input  logic [1:0]       E_md_read_E,
   output logic [WIDTH-1:0] E_writeData_E,
   output logic [WIDTH-1:0] E_ALU_out_E,
   output logic [REG_W-1:0] E_writeReg_E,
   output logic             E_md_stall_E,
   output logic             E_div_zero_E
);

   // 4:1 forwarding select: register file, W result, M result, zero.
   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] rd,
                                                 input logic [WIDTH-1:0] res_w,
                                                 input logic [WIDTH-1:0] alu_m);
      case (sel)
         2'b00:   return rd;
         2'b01:   return res_w;
         2'b10:   return alu_m;
         default: return {WIDTH{1'b0}};
      endcase
   endfunction

   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;
   logic             md_busy;

   // Operand forwarding, immediate select and destination register select.
   always_comb begin
      src_a         = fwd_mux(E_forwardA_E, E_RD1_E, E_Result_W, E_ALU_out_M);
      E_writeData_E = fwd_mux(E_forwardB_E, E_RD2_E, E_Result_W, E_ALU_out_M);
      if (E_ALUSrc_E) begin
         src_b = E_signImm_E;
      end else begin
         src_b = E_writeData_E;
      end
      if (E_reg_dest_E) begin
         E_writeReg_E = E_Rd_E;
      end else begin
         E_writeReg_E = E_Rt_E;
      end
   end

   // Combinational ALU.
   always_comb begin
      case (E_ALU_control_E)
         ALU_AND:  alu_res = src_a & src_b;
         ALU_OR:   alu_res = src_a | src_b;
         ALU_ADD:  alu_res = src_a + src_b;
         ALU_ANDN: alu_res = src_a & ~src_b;
         ALU_ORN:  alu_res = src_a | ~src_b;
         ALU_SUB:  alu_res = src_a - src_b;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default:  alu_res = {WIDTH{1'b0}};
      endcase
   end

   // Stage result select and stall request while the mul/div unit is busy.
   always_comb begin
      case (E_md_read_E)
         MDR_HI:  E_ALU_out_E = md_hi;
         MDR_LO:  E_ALU_out_E = md_lo;
         default: E_ALU_out_E = alu_res;
      endcase
      E_md_stall_E = md_busy && (is_md_use(E_md_op_E) ||
                                 (E_md_read_E == MDR_HI) || (E_md_read_E == MDR_LO));
   end

   mul_div_unit #(.WIDTH(WIDTH)) u_md (
      .clk      (clk),
      .rst      (rst),
      .op       (E_md_op_E),
      .src_a    (src_a),
      .src_b    (E_writeData_E),
      .hi       (md_hi),
      .lo       (md_lo),
      .busy     (md_busy),
      .div_zero (E_div_zero_E)
   );

endmodule
